// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: on request, writes one of two parameter presets
// into a PLL reconfig core over Avalon-MM, starts the reconfiguration, waits a fixed
// settle time and then waits (bounded) for the PLL to relock.
module pll_reconfig_seq #(
   parameter logic [17:0] N_WORD       = 18'h10000,
   parameter logic [17:0] M_WORD0      = 18'h20504,
   parameter logic [17:0] M_WORD1      = 18'h20504,
   parameter logic [17:0] C0_WORD0     = 18'h20302,
   parameter logic [17:0] C0_WORD1     = 18'h20302,
   parameter logic [17:0] C1_WORD0     = 18'h00505,
   parameter logic [17:0] C1_WORD1     = 18'h00505,
   parameter logic [31:0] K_WORD0      = 32'd2865308404,
   parameter logic [31:0] K_WORD1      = 32'd2865308404,
   parameter int unsigned SETTLE       = 16,
   parameter int unsigned LOCK_TIMEOUT = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        preset_sel,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        active_preset,
   output logic        active_valid,
   output logic [5:0]  mgmt_address,
   output logic        mgmt_write,
   output logic [31:0] mgmt_writedata,
   input  logic        mgmt_waitrequest,
   input  logic        pll_locked
);

   typedef enum logic [3:0] {
      StIdle,
      StWrMode,
      StWrN,
      StWrM,
      StWrC0,
      StWrC1,
      StWrK,
      StWrStart,
      StSettle,
      StLockWait
   } state_e;

   // A SETTLE of 0 behaves like 1: the settle state always lasts at least one cycle.
   localparam logic [31:0] SettleLast = (SETTLE > 0) ? 32'(SETTLE - 1) : 32'd0;
   localparam logic [31:0] LockLast   = (LOCK_TIMEOUT > 0) ? 32'(LOCK_TIMEOUT - 1) : 32'd0;

   state_e      state_q, state_d;
   logic        preset_q, preset_d;
   logic [31:0] cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        act_preset_q, act_preset_d;
   logic        act_valid_q, act_valid_d;
   logic        sync1_q;
   logic        locked_s;
   logic        wr_ok;

   // Avalon write decode: purely a function of the current state and latched preset,
   // so address/data stay stable for as long as waitrequest stalls the write.
   always_comb begin
      mgmt_write     = 1'b0;
      mgmt_address   = 6'h00;
      mgmt_writedata = 32'h0;
      case (state_q)
         StWrMode: begin
            mgmt_write     = 1'b1;
            mgmt_address   = 6'h00;
            mgmt_writedata = 32'h0;
         end
         StWrN: begin
            mgmt_write     = 1'b1;
            mgmt_address   = 6'h03;
            mgmt_writedata = {14'b0, N_WORD};
         end
         StWrM: begin
            mgmt_write     = 1'b1;
            mgmt_address   = 6'h04;
            mgmt_writedata = {14'b0, (preset_q ? M_WORD1 : M_WORD0)};
         end
         StWrC0: begin
            mgmt_write     = 1'b1;
            mgmt_address   = 6'h05;
            mgmt_writedata = {9'b0, 5'd0, (preset_q ? C0_WORD1 : C0_WORD0)};
         end
         StWrC1: begin
            mgmt_write     = 1'b1;
            mgmt_address   = 6'h05;
            mgmt_writedata = {9'b0, 5'd1, (preset_q ? C1_WORD1 : C1_WORD0)};
         end
         StWrK: begin
            mgmt_write     = 1'b1;
            mgmt_address   = 6'h07;
            mgmt_writedata = preset_q ? K_WORD1 : K_WORD0;
         end
         StWrStart: begin
            mgmt_write     = 1'b1;
            mgmt_address   = 6'h02;
            mgmt_writedata = 32'h1;
         end
         default: ;
      endcase
   end

   assign wr_ok = mgmt_write & ~mgmt_waitrequest;

   // Next-state logic: advance one write per accepted transfer, then settle and lock wait.
   always_comb begin
      state_d      = state_q;
      preset_d     = preset_q;
      cnt_d        = cnt_q;
      done_d       = 1'b0;
      err_d        = err_q;
      act_preset_d = act_preset_q;
      act_valid_d  = act_valid_q;
      case (state_q)
         StIdle: begin
            if (req) begin
               err_d = 1'b0;
               if (act_valid_q && (preset_sel == act_preset_q)) begin
                  // Preset already loaded and locked: nothing to write.
                  done_d = 1'b1;
               end else begin
                  preset_d = preset_sel;
                  state_d  = StWrMode;
               end
            end
         end
         StWrMode: begin
            if (wr_ok) begin
               state_d     = StWrN;
               // PLL contents are undefined from here until relock.
               act_valid_d = 1'b0;
            end
         end
         StWrN:  if (wr_ok) state_d = StWrM;
         StWrM:  if (wr_ok) state_d = StWrC0;
         StWrC0: if (wr_ok) state_d = StWrC1;
         StWrC1: if (wr_ok) state_d = StWrK;
         StWrK:  if (wr_ok) state_d = StWrStart;
         StWrStart: begin
            if (wr_ok) begin
               state_d = StSettle;
               cnt_d   = 32'd0;
            end
         end
         StSettle: begin
            if (cnt_q >= SettleLast) begin
               state_d = StLockWait;
               cnt_d   = 32'd0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StLockWait: begin
            if (locked_s) begin
               state_d      = StIdle;
               done_d       = 1'b1;
               act_preset_d = preset_q;
               act_valid_d  = 1'b1;
            end else if (cnt_q >= LockLast) begin
               state_d     = StIdle;
               err_d       = 1'b1;
               act_valid_d = 1'b0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers and the two-flop lock synchronizer; reset aborts everything at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         preset_q     <= 1'b0;
         cnt_q        <= 32'd0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         act_preset_q <= 1'b0;
         act_valid_q  <= 1'b0;
         sync1_q      <= 1'b0;
         locked_s     <= 1'b0;
      end else begin
         state_q      <= state_d;
         preset_q     <= preset_d;
         cnt_q        <= cnt_d;
         done_q       <= done_d;
         err_q        <= err_d;
         act_preset_q <= act_preset_d;
         act_valid_q  <= act_valid_d;
         sync1_q      <= pll_locked;
         locked_s     <= sync1_q;
      end
   end

   assign busy          = (state_q != StIdle);
   assign done          = done_q;
   assign err           = err_q;
   assign active_preset = act_preset_q;
   assign active_valid  = act_valid_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: table vectors, a reset-abort sequence and random
// transactions, all checked cycle by cycle against a timeline computed up front.
module tb_pll_reconfig_seq;

   localparam int unsigned SETTLE = 16;
   localparam int unsigned LT     = 100;
   localparam int          MAXC   = 512;
   localparam logic [17:0] NW     = 18'h10000;
   localparam logic [17:0] M0     = 18'h20504;
   localparam logic [17:0] M1     = 18'h20606;
   localparam logic [17:0] C00    = 18'h20302;
   localparam logic [17:0] C01    = 18'h20403;
   localparam logic [17:0] C10    = 18'h00505;
   localparam logic [17:0] C11    = 18'h00707;
   localparam logic [31:0] K0     = 32'd2865308404;
   localparam logic [31:0] K1     = 32'h1234_5678;

   logic        clk = 1'b0;
   logic        rst, req, preset_sel, mgmt_waitrequest, pll_locked;
   logic        busy, done, err, active_preset, active_valid, mgmt_write;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference view of the block's persistent status.
   bit m_av  = 1'b0;
   bit m_ap  = 1'b0;
   bit m_err = 1'b0;

   typedef struct {
      bit preset;
      int pct;
      int sidx;
      int slen;
      int ldly;
      bit ign;
      int exp_outcome;  // 0 done, 1 timeout, 2 skipped
   } vec_t;

   vec_t vecs[9];

   pll_reconfig_seq #(
      .N_WORD(NW), .M_WORD0(M0), .M_WORD1(M1), .C0_WORD0(C00), .C0_WORD1(C01),
      .C1_WORD0(C10), .C1_WORD1(C11), .K_WORD0(K0), .K_WORD1(K1),
      .SETTLE(SETTLE), .LOCK_TIMEOUT(LT)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .preset_sel(preset_sel), .busy(busy),
      .done(done), .err(err), .active_preset(active_preset), .active_valid(active_valid),
      .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
      .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest),
      .pll_locked(pll_locked)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] exp_addr(input int k);
      case (k)
         0: return 6'h00;
         1: return 6'h03;
         2: return 6'h04;
         3: return 6'h05;
         4: return 6'h05;
         5: return 6'h07;
         default: return 6'h02;
      endcase
   endfunction

   function automatic logic [31:0] exp_data(input int k, input bit p);
      case (k)
         0: return 32'h0;
         1: return {14'b0, NW};
         2: return {14'b0, (p ? M1 : M0)};
         3: return {9'b0, 5'd0, (p ? C01 : C00)};
         4: return {9'b0, 5'd1, (p ? C11 : C10)};
         5: return p ? K1 : K0;
         default: return 32'h1;
      endcase
   endfunction

   function automatic logic [43:0] dut_vec();
      return {mgmt_write, mgmt_address, mgmt_writedata, busy, done, err, active_valid,
              active_preset};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One request plus its whole expected timeline. Offsets are cycles after the req cycle.
   task automatic run_txn(input bit p, input int pct, input int sidx, input int slen,
                          input int ldly, input bit ign, input int exp_outcome);
      bit   waitv[MAXC];
      int   st[7];
      int   cp[7];
      int   cursor, c, run, endo, e, lw, lo;
      bit   skip, ok, saw_done, prev_av, prev_ap, prev_err;
      bit   w;
      logic [5:0]  ea;
      logic [31:0] ed;
      logic [43:0] ev;
      int   act_out, mod_out;
      prev_av  = m_av;
      prev_ap  = m_ap;
      prev_err = m_err;
      run = 0;
      for (int i = 0; i < MAXC; i++) begin
         if (($urandom_range(99) < pct) && (run < 8)) begin
            waitv[i] = 1'b1;
            run++;
         end else begin
            waitv[i] = 1'b0;
            run = 0;
         end
      end
      for (int k = 0; k < 7; k++) begin
         st[k] = 0;
         cp[k] = -1;
      end
      skip = m_av && (p == m_ap);
      lo   = MAXC;
      if (skip) begin
         ok   = 1'b1;
         endo = 1;
      end else begin
         cursor = 1;
         for (int k = 0; k < 7; k++) begin
            st[k] = cursor;
            if (k == sidx) begin
               for (int j = 0; j < slen; j++) waitv[cursor + j] = 1'b1;
               waitv[cursor + slen] = 1'b0;
            end
            c = cursor;
            while (waitv[c]) c++;
            cp[k]  = c;
            cursor = c + 1;
         end
         e = cp[6] + int'(SETTLE) + 1;
         if (ldly < 0) begin
            lw = 1 << 30;
         end else begin
            lo = cp[6] + ldly;
            lw = (e > lo + 2) ? e : lo + 2;
         end
         if (lw - e < int'(LT)) begin
            ok   = 1'b1;
            endo = lw + 1;
         end else begin
            ok   = 1'b0;
            endo = e + int'(LT);
         end
      end
      saw_done = 1'b0;
      for (int o = 0; o <= endo + 1; o++) begin
         req = (o == 0) || (ign && !skip && (o >= 1) && (o < endo) && ($urandom_range(3) == 0));
         preset_sel       = (o == 0) ? p : 1'($urandom_range(1));
         mgmt_waitrequest = waitv[o];
         pll_locked       = skip ? 1'b1 : (o >= lo);
         @(negedge clk);
         w  = 1'b0;
         ea = 6'h0;
         ed = 32'h0;
         for (int k = 0; k < 7; k++) begin
            if (!skip && (o >= st[k]) && (o <= cp[k])) begin
               w  = 1'b1;
               ea = exp_addr(k);
               ed = exp_data(k, p);
            end
         end
         ev = {w, ea, ed,
               (!skip && (o >= 1) && (o < endo)),
               (ok && (o == endo)),
               ((o == 0) ? prev_err : ((o < endo) ? 1'b0 : !ok)),
               (skip ? prev_av : ((!skip && o < st[1]) ? prev_av : ((o < endo) ? 1'b0 : ok))),
               ((o >= endo && ok) ? p : prev_ap)};
         check($sformatf("cycle+%0d(p=%0d)", o, p), 64'(dut_vec()), 64'(ev));
         if (done) saw_done = 1'b1;
         @(posedge clk);
         #1;
      end
      req = 1'b0;
      act_out = skip ? 2 : (saw_done ? 0 : (err ? 1 : 3));
      mod_out = skip ? 2 : (ok ? 0 : 1);
      check("outcome", 64'(act_out), 64'((exp_outcome >= 0) ? exp_outcome : mod_out));
      if (!skip) begin
         m_err = !ok;
         m_av  = ok;
         if (ok) m_ap = p;
      end else begin
         m_err = 1'b0;
      end
   endtask

   initial begin
      rst              = 1'b1;
      req              = 1'b0;
      preset_sel       = 1'b0;
      mgmt_waitrequest = 1'b0;
      pll_locked       = 1'b0;

      vecs[0] = '{1'b1, 0, -1, 0, 5, 1'b0, 0};
      vecs[1] = '{1'b1, 0, -1, 0, 5, 1'b0, 2};
      vecs[2] = '{1'b0, 0, 2, 3, 5, 1'b0, 0};
      vecs[3] = '{1'b1, 0, -1, 0, -1, 1'b0, 1};
      vecs[4] = '{1'b1, 30, -1, 0, 20, 1'b1, 0};
      vecs[5] = '{1'b0, 0, -1, 0, int'(SETTLE + LT) - 2, 1'b0, 0};
      vecs[6] = '{1'b1, 0, -1, 0, int'(SETTLE + LT) - 1, 1'b0, 1};
      vecs[7] = '{1'b0, 50, -1, 0, 40, 1'b1, 0};
      vecs[8] = '{1'b0, 0, -1, 0, 5, 1'b0, 2};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", 64'(dut_vec()), 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_txn(vecs[i].preset, vecs[i].pct, vecs[i].sidx, vecs[i].slen, vecs[i].ldly,
                 vecs[i].ign, vecs[i].exp_outcome);
      end

      // Reset while the C1 write is stalled: abort with no START write.
      req        = 1'b1;
      preset_sel = m_av ? !m_ap : 1'b0;
      pll_locked = 1'b0;
      for (int o = 0; o < 5; o++) begin
         @(posedge clk);
         #1;
         req = 1'b0;
      end
      mgmt_waitrequest = 1'b1;
      rst              = 1'b1;
      @(negedge clk);
      check("c1_pending", 64'({mgmt_write, mgmt_address, mgmt_writedata}),
            64'({1'b1, 6'h05, 9'b0, 5'd1, (preset_sel ? C11 : C10)}));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("after_rst", 64'(dut_vec()), 64'h0);
      for (int o = 0; o < 20; o++) begin
         @(posedge clk);
         #1;
         mgmt_waitrequest = 1'($urandom_range(1));
         @(negedge clk);
         check($sformatf("idle_after_rst+%0d", o), 64'(dut_vec()), 64'h0);
      end
      m_av  = 1'b0;
      m_ap  = 1'b0;
      m_err = 1'b0;

      // Reset and request in the same cycle: reset wins.
      @(posedge clk);
      #1;
      rst = 1'b1;
      req = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = 1'b0;
      for (int o = 0; o < 3; o++) begin
         @(negedge clk);
         check($sformatf("rst_over_req+%0d", o), 64'(dut_vec()), 64'h0);
         @(posedge clk);
         #1;
      end

      for (int i = 0; i < 25; i++) begin
         run_txn(1'($urandom_range(1)), int'($urandom_range(60)), -1, 0,
                 ($urandom_range(9) == 0) ? -1 : int'($urandom_range(130)),
                 1'($urandom_range(1)), -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_reconfig_seq.md
PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

Interface
REQ-001 SHALL have parameter N_WORD, default 18'h10000, meaning N counter word (bypass set), shared by both presets.
REQ-002 SHALL have parameters M_WORD0/M_WORD1, default 18'h20504, meaning 18-bit M counter word for preset 0/1.
REQ-003 SHALL have parameters C0_WORD0/C0_WORD1, default 18'h20302, and C1_WORD0/C1_WORD1, default 18'h00505, meaning outclk_0/outclk_1 counter words per preset.
REQ-004 SHALL have parameters K_WORD0/K_WORD1, default 32'd2865308404, meaning fractional K per preset.
REQ-005 SHALL have parameter SETTLE, default 16, meaning cycles after START during which locked is ignored.
REQ-006 SHALL have parameter LOCK_TIMEOUT, default 1_000_000, meaning cycles allowed for relock.
REQ-007 SHALL have: clk  in  1  management clock; the single clock of the block.
REQ-008 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-009 SHALL have: req  in  1  one-cycle reconfiguration request.
REQ-010 SHALL have: preset_sel  in  1  preset to load; sampled with req.
REQ-011 SHALL have: busy  out  1  high from request acceptance until done/err.
REQ-012 SHALL have: done  out  1  one-cycle pulse on successful completion.
REQ-013 SHALL have: err  out  1  sticky lock-timeout flag.
REQ-014 SHALL have: active_preset  out  1  last successfully loaded preset; active_valid  out  1  active_preset meaningful.
REQ-015 SHALL have: mgmt_address  out  6, mgmt_write  out  1, mgmt_writedata  out  32, mgmt_waitrequest  in  1  Avalon-MM master to the PLL reconfig core.
REQ-016 SHALL have: pll_locked  in  1  PLL lock, asynchronous to clk.

Function
REQ-017 SHALL synchronize pll_locked through two clk flops (locked_s); only locked_s is used.
REQ-018 SHALL accept req only in IDLE; req while busy SHALL be ignored, no queuing.
REQ-019 SHALL, on accepted req with active_valid=1 and preset_sel==active_preset, skip all writes: done pulse next cycle, busy never asserted.
REQ-020 SHALL clear err on any accepted req.
REQ-021 SHALL sequence states IDLE -> WR_MODE -> WR_N -> WR_M -> WR_C0 -> WR_C1 -> WR_K -> WR_START -> SETTLE -> LOCK_WAIT -> IDLE.
REQ-022 Write addresses/data: MODE 0x00/0; N 0x03/{14'b0,N_WORD}; M 0x04/{14'b0,M_WORDx}; C0 0x05/{9'b0,5'd0,C0_WORDx}; C1 0x05/{9'b0,5'd1,C1_WORDx}; K 0x07/K_WORDx; START 0x02/1.
REQ-023 Handshake: mgmt_write, mgmt_address, mgmt_writedata SHALL be held stable while mgmt_waitrequest=1; write completes on the cycle mgmt_write=1 and mgmt_waitrequest=0; next write SHALL start the following cycle.
REQ-024 mgmt_write SHALL be 0 outside WR_* states; mgmt_address/mgmt_writedata SHALL be 0 when mgmt_write=0.
REQ-025 With mgmt_waitrequest held 0, req at cycle T SHALL give writes at T+1..T+7 (MODE..START), one per cycle.
REQ-026 SETTLE SHALL last exactly SETTLE cycles after START completion regardless of locked_s.
REQ-027 LOCK_WAIT: locked_s=1 -> done pulse next cycle, busy falls with it, active_preset<=preset latched, active_valid<=1.
REQ-028 LOCK_WAIT: LOCK_TIMEOUT cycles without locked_s -> err<=1, active_valid<=0, busy falls, no done, return IDLE.
REQ-029 Timeout counter SHALL reset on entry to LOCK_WAIT and saturate; it SHALL not wrap.
REQ-030 active_valid SHALL clear when WR_N begins (PLL contents undefined until relock).
REQ-031 busy SHALL be high exactly from the cycle after acceptance through the done/err cycle's predecessor.

Reset
REQ-032 rst SHALL force IDLE, busy=0, done=0, err=0, active_preset=0, active_valid=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, synchronizer flops=0.
REQ-033 rst mid-sequence SHALL abort immediately, including a write pending on waitrequest; no further writes issued; PLL left as-is.
REQ-034 rst SHALL take priority over req in the same cycle.

Verification
REQ-035 waitrequest=0, req, preset_sel=1, locked low 5 cycles after START then high -> 7 writes at T+1..T+7 with K=K_WORD1, done after SETTLE+sync, active_preset=1, active_valid=1.
REQ-036 waitrequest=1 for 3 cycles on WR_M -> M write held stable 4 cycles, C0 write starts cycle after acceptance, total sequence extended by exactly 3.
REQ-037 Repeat req with preset_sel=1 after REQ-035 -> done at T+1, zero mgmt_write cycles, busy stays 0.
REQ-038 LOCK_TIMEOUT=100, pll_locked held 0 -> err=1 at LOCK_TIMEOUT after LOCK_WAIT entry, no done, active_valid=0; next req clears err.
REQ-039 req pulses during busy -> ignored, exactly one sequence of 7 writes.
REQ-040 rst asserted during WR_C1 with waitrequest=1 -> next cycle mgmt_write=0, all outputs at reset values, no START issued.
